// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-map access arbiter.
package reg_arb_pkg;

   localparam int REG_ADDR_W = 16;
   localparam int REG_DATA_W = 16;

   // Value returned in rsp_rdata on any error response
   localparam logic [REG_DATA_W-1:0] ERR_DATA_DEF = 16'hDEAD;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_RD_WAIT = 2'd2,
      ARB_RESP    = 2'd3
   } arb_state_t;

   // Unsigned 16-bit range check; the highest legal address itself is legal
   function automatic logic addr_in_range(input logic [REG_ADDR_W-1:0] addr,
                                          input logic [REG_ADDR_W-1:0] addr_max);
      return (addr <= addr_max);
   endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Request/response bus of the requesters plus the register-map access port.
// The slave modport is the arbiter's view, master is the environment's view.
interface reg_access_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_write;
   logic [NUM_REQ*16-1:0] req_addr;
   logic [NUM_REQ*16-1:0] req_wdata;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic                  rsp_err;
   logic [15:0]           rsp_rdata;
   logic                  busy;
   logic                  reg_read_index;
   logic                  reg_data_index;
   logic [15:0]           reg_addr;
   logic [15:0]           reg_data;
   logic [15:0]           reg_read_out;
   logic                  read_data_en;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, reg_read_out, read_data_en,
      output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
             reg_read_index, reg_data_index, reg_addr, reg_data
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, reg_read_out, read_data_en,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
             reg_read_index, reg_data_index, reg_addr, reg_data
   );
endinterface

// File: rtl/reg_access_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The rotating pointer itself is owned by the parent.
module rr_arbiter #(
   parameter  int N    = 2,
   localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   input  logic            enable,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx
);

   logic w_found;

   // Scan requesters starting at ptr; the first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int   j;
         logic w_hit;
         j       = int'(ptr) + k;
         j       = (j >= N) ? (j - N) : j;
         w_hit   = enable && req[IDXW'(j)] && !w_found;
         gnt     = gnt | (N'(w_hit) << j);
         gnt_idx = w_hit ? IDXW'(j) : gnt_idx;
         w_found = w_found | w_hit;
      end
   end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares the single register-map access port between NUM_REQ requesters:
// round-robin grant, one transaction in flight, read-return wait with timeout
// and an address-range check that answers illegal addresses without touching the map.
module reg_access_arbiter
   import reg_arb_pkg::*;
#(
   parameter int                     NUM_REQ    = 2,
   parameter logic [REG_ADDR_W-1:0]  ADDR_MAX   = 16'h01FF,
   parameter int                     RD_TIMEOUT = 16,
   parameter logic [REG_DATA_W-1:0]  ERR_DATA   = ERR_DATA_DEF
) (
   input  logic                 eim_clk,
   input  logic                 eim_rst_n,
   reg_access_arbiter_if.slave  bus
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNTW = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(RD_TIMEOUT);

   arb_state_t              r_state;
   logic [IDXW-1:0]         r_ptr;
   logic [IDXW-1:0]         r_owner;
   logic                    r_write;
   logic [CNTW-1:0]         r_cnt;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic                    r_rsp_err;
   logic [REG_DATA_W-1:0]   r_rsp_rdata;
   logic                    r_reg_read_index;
   logic                    r_reg_data_index;
   logic [REG_ADDR_W-1:0]   r_reg_addr;
   logic [REG_DATA_W-1:0]   r_reg_data;

   logic                    w_idle;
   logic [NUM_REQ-1:0]      w_gnt;
   logic [IDXW-1:0]         w_gnt_idx;
   logic [IDXW-1:0]         w_ptr_nxt;
   logic [REG_ADDR_W-1:0]   w_sel_addr;
   logic [REG_DATA_W-1:0]   w_sel_wdata;
   logic                    w_sel_write;
   logic [NUM_REQ-1:0]      w_owner_oh;
   logic [CNTW-1:0]         w_cnt_inc;

   assign w_idle = (r_state == ARB_IDLE);

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (bus.req_valid),
      .ptr     (r_ptr),
      .enable  (w_idle),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   // Select the granted requester's command and derive next-pointer / counter values
   always_comb begin
      w_sel_addr  = bus.req_addr[REG_ADDR_W*int'(w_gnt_idx) +: REG_ADDR_W];
      w_sel_wdata = bus.req_wdata[REG_DATA_W*int'(w_gnt_idx) +: REG_DATA_W];
      w_sel_write = bus.req_write[w_gnt_idx];
      w_ptr_nxt   = (w_gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IDXW'(1'b1));
      w_owner_oh  = NUM_REQ'(1'b1) << r_owner;
      // Saturating increment: the timeout counter never wraps
      w_cnt_inc   = (r_cnt == CNT_LIMIT) ? r_cnt : (r_cnt + CNTW'(1'b1));
   end

   // Transaction sequencer: accept, strobe the map, wait for read data, respond once
   always_ff @(posedge eim_clk or negedge eim_rst_n) begin
      if (!eim_rst_n) begin
         r_state          <= ARB_IDLE;
         r_ptr            <= '0;
         r_owner          <= '0;
         r_write          <= 1'b0;
         r_cnt            <= '0;
         r_rsp_valid      <= '0;
         r_rsp_err        <= 1'b0;
         r_rsp_rdata      <= '0;
         r_reg_read_index <= 1'b0;
         r_reg_data_index <= 1'b0;
         r_reg_addr       <= '0;
         r_reg_data       <= '0;
      end else begin
         // Strobes and the response are single-cycle pulses unless re-armed below
         r_reg_read_index <= 1'b0;
         r_reg_data_index <= 1'b0;
         r_rsp_valid      <= '0;
         r_rsp_err        <= 1'b0;
         r_rsp_rdata      <= '0;
         case (r_state)
            ARB_IDLE: begin
               if (|w_gnt) begin
                  r_owner <= w_gnt_idx;
                  r_write <= w_sel_write;
                  r_ptr   <= w_ptr_nxt;
                  if (addr_in_range(w_sel_addr, ADDR_MAX)) begin
                     r_state          <= ARB_ISSUE;
                     r_reg_addr       <= w_sel_addr;
                     r_reg_data       <= w_sel_wdata;
                     r_reg_data_index <= w_sel_write;
                     r_reg_read_index <= ~w_sel_write;
                  end else begin
                     // Illegal address: answer directly, the map is never touched
                     r_state     <= ARB_RESP;
                     r_rsp_valid <= w_gnt;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= ERR_DATA;
                  end
               end else begin
                  r_state <= ARB_IDLE;
               end
            end
            ARB_ISSUE: begin
               r_cnt <= '0;
               if (r_write) begin
                  r_state     <= ARB_RESP;
                  r_rsp_valid <= w_owner_oh;
               end else if (bus.read_data_en) begin
                  r_state     <= ARB_RESP;
                  r_rsp_valid <= w_owner_oh;
                  r_rsp_rdata <= bus.reg_read_out;
               end else begin
                  r_state <= ARB_RD_WAIT;
               end
            end
            ARB_RD_WAIT: begin
               if (bus.read_data_en) begin
                  r_state     <= ARB_RESP;
                  r_rsp_valid <= w_owner_oh;
                  r_rsp_rdata <= bus.reg_read_out;
               end else if (w_cnt_inc == CNT_LIMIT) begin
                  r_state     <= ARB_RESP;
                  r_cnt       <= w_cnt_inc;
                  r_rsp_valid <= w_owner_oh;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= ERR_DATA;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ARB_RESP: begin
               r_state <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Accept is only offered in IDLE and is forced low while reset is asserted
   assign bus.req_ready      = w_gnt & {NUM_REQ{eim_rst_n}};
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_err        = r_rsp_err;
   assign bus.rsp_rdata      = r_rsp_rdata;
   assign bus.busy           = ~w_idle;
   assign bus.reg_read_index = r_reg_read_index;
   assign bus.reg_data_index = r_reg_data_index;
   assign bus.reg_addr       = r_reg_addr;
   assign bus.reg_data       = r_reg_data;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a transaction-timeline reference model
// checked against every output on every falling clock edge.
module tb_reg_access_arbiter;
   import reg_arb_pkg::*;

   localparam int          N          = 2;
   localparam logic [15:0] ADDR_MAX   = 16'h01FF;
   localparam int          RD_TIMEOUT = 16;
   localparam logic [15:0] ERR_DATA   = 16'hDEAD;

   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   reg_access_arbiter_if #(.NUM_REQ(N)) bus ();

   reg_access_arbiter #(
      .NUM_REQ(N), .ADDR_MAX(ADDR_MAX), .RD_TIMEOUT(RD_TIMEOUT), .ERR_DATA(ERR_DATA)
   ) dut (
      .eim_clk   (clk),
      .eim_rst_n (rst_n),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Tracks a transaction as "age" = cycles since its accept.
   bit          m_busy;
   bit          m_inrsp;
   bit          m_write;
   int          m_age;
   int          m_owner;
   int          m_ptr;
   logic [N-1:0] e_rsp_valid;
   logic        e_err, e_rd, e_wr;
   logic [15:0] e_rdata, e_addr, e_data;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   initial begin : model
      int          g;
      int          a;
      logic [15:0] ad;
      m_busy = 0; m_inrsp = 0; m_write = 0; m_age = 0; m_owner = 0; m_ptr = 0;
      e_rsp_valid = '0; e_err = 0; e_rd = 0; e_wr = 0; e_rdata = '0; e_addr = '0; e_data = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_inrsp = 0; m_ptr = 0;
            e_rsp_valid = '0; e_err = 0; e_rd = 0; e_wr = 0; e_rdata = '0;
            e_addr = '0; e_data = '0;
         end else begin
            e_rsp_valid = '0; e_err = 0; e_rd = 0; e_wr = 0; e_rdata = '0;
            if (!m_busy) begin
               g = pick(bus.req_valid, m_ptr);
               if (g >= 0) begin
                  m_busy  = 1; m_age = 1; m_owner = g; m_inrsp = 0;
                  m_write = bus.req_write[g];
                  ad      = bus.req_addr[16*g +: 16];
                  m_ptr   = (g + 1) % N;
                  if (ad > ADDR_MAX) begin
                     e_rsp_valid[g] = 1'b1; e_err = 1; e_rdata = ERR_DATA; m_inrsp = 1;
                  end else begin
                     e_addr = ad;
                     e_data = bus.req_wdata[16*g +: 16];
                     if (m_write) e_wr = 1; else e_rd = 1;
                  end
               end
            end else if (m_inrsp) begin
               m_busy = 0; m_inrsp = 0;
            end else begin
               a = m_age; m_age = a + 1;
               if (m_write) begin
                  e_rsp_valid[m_owner] = 1'b1; m_inrsp = 1;
               end else if (bus.read_data_en) begin
                  e_rsp_valid[m_owner] = 1'b1; e_rdata = bus.reg_read_out; m_inrsp = 1;
               end else if (a == RD_TIMEOUT + 1) begin
                  e_rsp_valid[m_owner] = 1'b1; e_err = 1; e_rdata = ERR_DATA; m_inrsp = 1;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model
   initial begin : cmp
      logic [55:0]  act, exp;
      logic [N-1:0] er;
      int           g;
      forever begin
         @(negedge clk);
         g  = pick(bus.req_valid, m_ptr);
         er = '0;
         if (rst_n && !m_busy && g >= 0) er[g] = 1'b1;
         act = {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.busy,
                bus.reg_read_index, bus.reg_data_index, bus.reg_addr, bus.reg_data};
         exp = {er, e_rsp_valid, e_err, e_rdata, m_busy,
                e_rd, e_wr, e_addr, e_data};
         n_vec++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d outputs {ready,rsp,err,rdata,busy,rd,wr,addr,data}: got %h expected %h",
                     cyc, act, exp);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, output int t_acc);
      bit got;
      got   = 0;
      t_acc = -1;
      bus.req_write[idx]          = wr;
      bus.req_addr[16*idx +: 16]  = addr;
      bus.req_wdata[16*idx +: 16] = wd;
      bus.req_valid[idx]          = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready[idx]) begin
            got   = 1;
            t_acc = cyc;
         end
      end
      if (!got) begin
         n_vec++; n_bad++;
         $display("FAIL accept req%0d: got no req_ready within 50 cycles, expected an accept", idx);
      end
      @(posedge clk);
      #1;
      bus.req_valid[idx] = 1'b0;
   endtask

   task automatic wait_rsp(output int t_rsp);
      bit got;
      got   = 0;
      t_rsp = -1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (|bus.rsp_valid) begin
            got   = 1;
            t_rsp = cyc;
         end
      end
      if (!got) begin
         n_vec++; n_bad++;
         $display("FAIL response wait: got no rsp_valid within 60 cycles, expected one");
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running at 100us, expected completion");
      n_bad++;
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int t, tr, g;
      int gq[$];
      int gc[$];
      int exp3[4];
      exp3 = '{0, 1, 0, 1};

      rst_n = 1'b1;
      bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.reg_read_out = 16'h0000; bus.read_data_en = 1'b0;
      #1 rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset reg_addr", 32'(bus.reg_addr), 32'd0);

      // 1: write from req0, strobe at T+1, response at T+2
      issue(0, 1'b1, 16'h0010, 16'hA5A5, t);
      @(negedge clk);
      chk("t1 write strobe", 32'(bus.reg_data_index), 32'd1);
      chk("t1 reg_addr", 32'(bus.reg_addr), 32'h0010);
      chk("t1 reg_data", 32'(bus.reg_data), 32'hA5A5);
      wait_rsp(tr);
      chk("t1 latency", 32'(tr - t), 32'd2);
      chk("t1 rsp_valid", 32'(bus.rsp_valid), 32'b01);
      chk("t1 rsp_err", 32'(bus.rsp_err), 32'd0);

      // 2: read from req1, map answers 3 cycles after the strobe
      issue(1, 1'b0, 16'h00FF, 16'h0000, t);
      tick(3);
      bus.read_data_en = 1'b1; bus.reg_read_out = 16'h0047;
      tick(1);
      bus.read_data_en = 1'b0; bus.reg_read_out = 16'h0000;
      wait_rsp(tr);
      chk("t2 latency", 32'(tr - t), 32'd5);
      chk("t2 rsp_valid", 32'(bus.rsp_valid), 32'b10);
      chk("t2 rsp_rdata", 32'(bus.rsp_rdata), 32'h0047);
      chk("t2 rsp_err", 32'(bus.rsp_err), 32'd0);

      // 3: both requesters hold valid; grants alternate, one accept every 3 cycles
      bus.req_write = 2'b11;
      bus.req_addr  = {16'h0101, 16'h0100};
      bus.req_wdata = {16'h2222, 16'h1111};
      bus.req_valid = 2'b11;
      for (int i = 0; i < 40 && gq.size() < 4; i++) begin
         @(negedge clk);
         if (|bus.req_ready) begin
            gq.push_back(bus.req_ready[1] ? 1 : 0);
            gc.push_back(cyc);
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      chk("t3 grant count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < gq.size()) chk("t3 grant order", 32'(gq[i]), 32'(exp3[i]));
         if (i > 0 && i < gc.size()) chk("t3 accept spacing", 32'(gc[i] - gc[i-1]), 32'd3);
      end
      wait_rsp(tr);

      // 4: read with no answer times out; a stray read_data_en afterwards is ignored
      issue(0, 1'b0, 16'h0020, 16'h0000, t);
      wait_rsp(tr);
      chk("t4 timeout latency", 32'(tr - t), 32'd18);
      chk("t4 rsp_err", 32'(bus.rsp_err), 32'd1);
      chk("t4 rsp_rdata", 32'(bus.rsp_rdata), 32'hDEAD);
      chk("t4 rsp_valid", 32'(bus.rsp_valid), 32'b01);
      tick(1);
      bus.read_data_en = 1'b1; bus.reg_read_out = 16'h5555;
      tick(1);
      bus.read_data_en = 1'b0; bus.reg_read_out = 16'h0000;
      @(negedge clk);
      chk("t4 stray ignored busy", 32'(bus.busy), 32'd0);
      chk("t4 stray ignored rsp", 32'(bus.rsp_valid), 32'd0);

      // 4b: answer exactly RD_TIMEOUT cycles after the strobe is still accepted
      issue(1, 1'b0, 16'h0030, 16'h0000, t);
      tick(16);
      bus.read_data_en = 1'b1; bus.reg_read_out = 16'h1234;
      tick(1);
      bus.read_data_en = 1'b0; bus.reg_read_out = 16'h0000;
      wait_rsp(tr);
      chk("t4b latency", 32'(tr - t), 32'd18);
      chk("t4b rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("t4b rsp_rdata", 32'(bus.rsp_rdata), 32'h1234);

      // 4c: answer in the strobe cycle itself
      issue(0, 1'b0, 16'h01FF, 16'h0000, t);
      bus.read_data_en = 1'b1; bus.reg_read_out = 16'h00AA;
      tick(1);
      bus.read_data_en = 1'b0; bus.reg_read_out = 16'h0000;
      wait_rsp(tr);
      chk("t4c latency", 32'(tr - t), 32'd2);
      chk("t4c rsp_rdata", 32'(bus.rsp_rdata), 32'h00AA);

      // 5: address range boundary
      issue(1, 1'b1, 16'h0200, 16'hBEEF, t);
      wait_rsp(tr);
      chk("t5 illegal latency", 32'(tr - t), 32'd1);
      chk("t5 illegal err", 32'(bus.rsp_err), 32'd1);
      chk("t5 illegal rdata", 32'(bus.rsp_rdata), 32'hDEAD);
      chk("t5 illegal rsp_valid", 32'(bus.rsp_valid), 32'b10);
      issue(0, 1'b1, 16'h01FF, 16'hCAFE, t);
      @(negedge clk);
      chk("t5 max addr strobe", 32'(bus.reg_data_index), 32'd1);
      chk("t5 max addr reg_addr", 32'(bus.reg_addr), 32'h01FF);
      wait_rsp(tr);
      chk("t5 max addr latency", 32'(tr - t), 32'd2);
      chk("t5 max addr err", 32'(bus.rsp_err), 32'd0);
      issue(1, 1'b0, 16'hFFFF, 16'h0000, t);
      wait_rsp(tr);
      chk("t5 ffff latency", 32'(tr - t), 32'd1);
      chk("t5 ffff err", 32'(bus.rsp_err), 32'd1);

      // 6: reset while waiting for read data; pointer returns to requester 0
      issue(0, 1'b0, 16'h0040, 16'h0000, t);
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 reset busy", 32'(bus.busy), 32'd0);
      chk("t6 reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t6 reset reg_addr", 32'(bus.reg_addr), 32'd0);
      tick(2);
      rst_n = 1'b1;
      bus.req_write = 2'b11;
      bus.req_addr  = {16'h0050, 16'h0050};
      bus.req_valid = 2'b11;
      g = -1;
      for (int i = 0; i < 10 && g < 0; i++) begin
         @(negedge clk);
         if (|bus.req_ready) g = bus.req_ready[1] ? 1 : 0;
      end
      chk("t6 grant after reset", 32'(g), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      wait_rsp(tr);
      chk("t6 rsp_valid", 32'(bus.rsp_valid), 32'b01);
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
